// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // FUNCT3 encodings of the M-extension ops
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Divide-by-zero quotient and most negative signed value
  localparam logic [XLEN_DEFAULT-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN_DEFAULT-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Multiply: acc = {product_hi, product_lo}, bit_i is the current multiplier bit.
// Divide:   acc = {remainder, quotient},   bit_i is the next dividend bit (MSB first).
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  input  logic              bit_i,
  input  logic              is_div_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;

  // Next accumulator for a single iteration
  always_comb begin
    acc_o = acc_i;
    sum   = '0;
    trial = '0;
    if (!is_div_i) begin
      sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (bit_i ? {1'b0, operand_i} : '0);
      acc_o = {sum, acc_i[XLEN-1:1]};
    end else begin
      // Remainder is always below the divisor, so the shifted value fits in XLEN+1 bits
      trial = {acc_i[2*XLEN-1:XLEN], bit_i} - {1'b0, operand_i};
      if (!trial[XLEN]) begin
        acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {acc_i[2*XLEN-2:XLEN], bit_i, acc_i[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execute unit: iterates on operand magnitudes, applies
// sign fixup, and holds the pipeline via STALL until the result is ready.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = 5
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic [XLEN-1:0] RESULT,
  output logic            DONE,
  output logic            STALL,
  output logic            BUSY
);

  state_e              state_q;
  logic [2:0]          f3_q;
  logic                s1_q, s2_q;
  logic [XLEN-1:0]     a_q, b_q;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [XLEN-1:0]     result_q;

  logic                is_div, sgn1, sgn2, neg1, neg2;
  logic [XLEN-1:0]     mag1, mag2;
  logic                fast_div0, fast_ovf;
  logic [XLEN-1:0]     fast_res;
  logic [CNT_W-1:0]    rev_idx;
  logic                step_bit;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix, rem_fix, fix_res;

  // Operand decode, magnitudes and fast-path detection at op acceptance
  always_comb begin
    is_div    = FUNCT3[2];
    sgn1      = (FUNCT3 == F3_MULH) || (FUNCT3 == F3_MULHSU) ||
                (FUNCT3 == F3_DIV)  || (FUNCT3 == F3_REM);
    sgn2      = (FUNCT3 == F3_MULH) || (FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM);
    neg1      = sgn1 & DATA1[XLEN-1];
    neg2      = sgn2 & DATA2[XLEN-1];
    mag1      = neg1 ? -DATA1 : DATA1;
    mag2      = neg2 ? -DATA2 : DATA2;
    fast_div0 = is_div && (DATA2 == '0);
    fast_ovf  = ((FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM)) &&
                (DATA1 == INT_MIN) && (DATA2 == '1);
    fast_res  = '0;
    if (fast_div0) begin
      fast_res = FUNCT3[1] ? DATA1 : DIV0_QUOT;
    end else if (fast_ovf) begin
      fast_res = FUNCT3[1] ? '0 : INT_MIN;
    end
  end

  // Multiply consumes multiplier bits LSB first, divide consumes dividend bits MSB first
  always_comb begin
    rev_idx  = CNT_W'(XLEN - 1) - cnt_q;
    step_bit = f3_q[2] ? a_q[rev_idx] : a_q[cnt_q];
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i     (acc_q),
    .operand_i (b_q),
    .bit_i     (step_bit),
    .is_div_i  (f3_q[2]),
    .acc_o     (acc_d)
  );

  // Sign fixup and result word selection
  always_comb begin
    prod_fix = (s1_q ^ s2_q) ? -acc_q : acc_q;
    quot_fix = (s1_q ^ s2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = s1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = quot_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  // Sequencer FSM with operand, accumulator, counter and result registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START && !FLUSH) begin
            f3_q  <= FUNCT3;
            s1_q  <= neg1;
            s2_q  <= neg2;
            a_q   <= mag1;
            b_q   <= mag2;
            acc_q <= '0;
            cnt_q <= '0;
            if (fast_div0 || fast_ovf) begin
              result_q <= fast_res;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (FLUSH) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) begin
              state_q <= S_FIXUP;
            end
          end
        end
        S_FIXUP: begin
          if (FLUSH) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= fix_res;
            state_q  <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign RESULT = result_q;
  assign DONE   = (state_q == S_DONE);
  assign BUSY   = (state_q != S_IDLE);
  assign STALL  = ((state_q == S_IDLE) && START && !FLUSH) ||
                  (state_q == S_CALC) || (state_q == S_FIXUP);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic        FLUSH;
  logic [2:0]  FUNCT3;
  logic [31:0] DATA1, DATA2;
  logic [31:0] RESULT;
  logic        DONE, STALL, BUSY;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_result;

  always #5 CLK = ~CLK;

  muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .START   (START),
    .FLUSH   (FLUSH),
    .FUNCT3  (FUNCT3),
    .DATA1   (DATA1),
    .DATA2   (DATA2),
    .RESULT  (RESULT),
    .DONE    (DONE),
    .STALL   (STALL),
    .BUSY    (BUSY)
  );

  // Issue one op and measure cycles to DONE and cycles with STALL high
  task automatic run_op(input logic [2:0] f3, input logic [31:0] d1, input logic [31:0] d2,
                        output int lat, output int stalls, output bit got, output bit stall_in_done);
    FUNCT3 = f3; DATA1 = d1; DATA2 = d2; START = 1'b1;
    #1;
    lat = 0; stalls = 0; got = 1'b0; stall_in_done = 1'b0;
    while (!got && lat < 200) begin
      if (STALL) stalls++;
      @(posedge CLK); #1;
      START = 1'b0;
      #1;
      lat++;
      if (DONE) begin
        got = 1'b1;
        stall_in_done = STALL;
      end
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; START = 1'b0; FLUSH = 1'b0; FUNCT3 = '0; DATA1 = '0; DATA2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++; if (RESULT !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected %h", RESULT, 32'h0); end
    n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", DONE); end
    n_checks++; if (STALL !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", STALL); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    last_result = 32'h0;
  endtask

  task automatic test_mul();
    int lat, stalls; bit got, sid;
    run_op(MUL, 32'd7, 32'hFFFF_FFFD, lat, stalls, got, sid);
    n_checks++; if (!got) begin n_fail++; $display("FAIL mul_done_seen: got no DONE expected DONE"); end
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL mul_latency: got %0d expected 34", lat); end
    n_checks++; if (stalls != 34) begin n_fail++; $display("FAIL mul_stall_cycles: got %0d expected 34", stalls); end
    n_checks++; if (sid !== 1'b0) begin n_fail++; $display("FAIL mul_stall_in_done: got %b expected 0", sid); end
    n_checks++; if (RESULT !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h expected %h", RESULT, 32'hFFFF_FFEB); end
    @(posedge CLK); #2;
    n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse: got %b expected 0", DONE); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL mul_idle_after: got %b expected 0", BUSY); end
    n_checks++; if (RESULT !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result_held: got %h expected %h", RESULT, 32'hFFFF_FFEB); end
    last_result = 32'hFFFF_FFEB;
  endtask

  task automatic test_mul_high();
    logic [2:0]  f3 [3] = '{MULH, MULHU, MULHSU};
    logic [31:0] a  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e  [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int lat, stalls; bit got, sid;
    for (int i = 0; i < 3; i++) begin
      run_op(f3[i], a[i], b[i], lat, stalls, got, sid);
      n_checks++; if (RESULT !== e[i] || lat != 34) begin n_fail++; $display("FAIL mulhigh_%0d: got %h lat %0d expected %h lat 34", i, RESULT, lat, e[i]); end
      @(posedge CLK); #1;
    end
    last_result = 32'hFFFF_FFFF;
  endtask

  task automatic test_div();
    logic [2:0]  f3 [4] = '{DIV, REM, DIVU, REMU};
    logic [31:0] a  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] e  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int lat, stalls; bit got, sid;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], a[i], b[i], lat, stalls, got, sid);
      n_checks++; if (RESULT !== e[i] || lat != 34) begin n_fail++; $display("FAIL div_%0d: got %h lat %0d expected %h lat 34", i, RESULT, lat, e[i]); end
      @(posedge CLK); #1;
    end
    last_result = 32'd2;
  endtask

  task automatic test_div_special();
    logic [2:0]  f3 [4] = '{DIV, REM, REMU, DIV};
    logic [31:0] a  [4] = '{32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
    logic [31:0] b  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] e  [4] = '{32'h8000_0000, 32'h0, 32'd5, 32'hFFFF_FFFF};
    int lat, stalls; bit got, sid;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], a[i], b[i], lat, stalls, got, sid);
      n_checks++; if (RESULT !== e[i]) begin n_fail++; $display("FAIL special_result_%0d: got %h expected %h", i, RESULT, e[i]); end
      n_checks++; if (lat != 1 || stalls != 1) begin n_fail++; $display("FAIL special_timing_%0d: got lat %0d stall %0d expected lat 1 stall 1", i, lat, stalls); end
      @(posedge CLK); #1;
    end
    last_result = 32'hFFFF_FFFF;
  endtask

  task automatic test_flush();
    int lat, stalls, dones; bit got, sid;
    FUNCT3 = MUL; DATA1 = 32'd5; DATA2 = 32'd6; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    #1;
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got busy %b expected 0", BUSY); end
    n_checks++; if (STALL !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", STALL); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (DONE) dones++;
      @(posedge CLK); #1;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses expected 0", dones); end
    n_checks++; if (RESULT !== last_result) begin n_fail++; $display("FAIL flush_result_held: got %h expected %h", RESULT, last_result); end
    FLUSH = 1'b1; START = 1'b1; FUNCT3 = DIVU; DATA1 = 32'd8; DATA2 = 32'd3;
    #1;
    n_checks++; if (STALL !== 1'b0) begin n_fail++; $display("FAIL flush_start_stall: got %b expected 0", STALL); end
    @(posedge CLK); #1;
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL flush_start_reject: got busy %b expected 0", BUSY); end
    FLUSH = 1'b0; START = 1'b0;
    run_op(DIVU, 32'd100, 32'd7, lat, stalls, got, sid);
    n_checks++; if (RESULT !== 32'd14 || lat != 34) begin n_fail++; $display("FAIL flush_recover: got %h lat %0d expected %h lat 34", RESULT, lat, 32'd14); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    int lat, stalls; bit got, sid;
    FUNCT3 = MUL; DATA1 = 32'd9; DATA2 = 32'd9; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    n_checks++; if (BUSY !== 1'b0 || STALL !== 1'b0 || DONE !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: got busy %b stall %b done %b expected 0 0 0", BUSY, STALL, DONE); end
    n_checks++; if (RESULT !== 32'h0) begin n_fail++; $display("FAIL midreset_result: got %h expected %h", RESULT, 32'h0); end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    run_op(MUL, 32'd3, 32'd4, lat, stalls, got, sid);
    n_checks++; if (RESULT !== 32'd12 || lat != 34) begin n_fail++; $display("FAIL midreset_recover: got %h lat %0d expected %h lat 34", RESULT, lat, 32'd12); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    int cyc, nd, d1c;
    FUNCT3 = MUL; DATA1 = 32'd3; DATA2 = 32'd4; START = 1'b1;
    cyc = 0; nd = 0; d1c = 0;
    while (nd < 2 && cyc < 200) begin
      @(posedge CLK); #1;
      cyc++;
      if (nd == 1 && cyc == d1c + 1) begin
        n_checks++; if (BUSY !== 1'b0 || STALL !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_gap: got busy %b stall %b expected 0 1", BUSY, STALL); end
      end
      if (DONE) begin
        if (nd == 0) begin
          d1c = cyc;
          n_checks++; if (RESULT !== 32'd12 || cyc != 34) begin n_fail++; $display("FAIL b2b_first: got %h at %0d expected %h at 34", RESULT, cyc, 32'd12); end
          FUNCT3 = DIVU; DATA1 = 32'd9; DATA2 = 32'd2;
        end else begin
          n_checks++; if (RESULT !== 32'd4) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", RESULT, 32'd4); end
          n_checks++; if (cyc - d1c != 35) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 35", cyc - d1c); end
        end
        nd++;
      end
    end
    START = 1'b0;
    n_checks++; if (nd != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", nd); end
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_div_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle RV32M execute unit sequencer, sitting in the EX stage beside the ALU.
- Accepts a MUL/DIV-class op (ALUOP[0]=1; ALUOP[4:2]=FUNCT3) and runs a radix-2 iterative shift-add multiply or restoring divide on operand magnitudes.
- Applies sign fixup, then returns a 32-bit result.
- Drives STALL to freeze the IF/ID/EX pipeline registers until the result is ready.

Parameters:
XLEN, 32, operand/result width
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
START  in  1  EX holds a valid M-extension op (ALUOP[0] & stage valid)
FLUSH  in  1  EX-stage flush (branch/jump taken); aborts the current op
FUNCT3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
DATA1  in  XLEN  rs1 operand
DATA2  in  XLEN  rs2 operand
RESULT  out  XLEN  registered result; valid when DONE=1, held until the next DONE
DONE  out  1  one-cycle result-valid pulse
STALL  out  1  combinational pipeline hold request
BUSY  out  1  state != IDLE

Behaviour:
- Reset (RESET_N=0, async, any state):
  - state=IDLE; RESULT=0; counter=0; all internal registers=0.
  - DONE=0, STALL=0, BUSY=0.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - START=0 → stay in IDLE.
  - START=1 → latch FUNCT3, sign flags, |DATA1|, |DATA2|; clear the 64-bit accumulator and counter.
    - Next state is CALC, or DONE on the fast path.
  - Sign rules:
    - DATA1 is signed for MULH, MULHSU, DIV, REM.
    - DATA2 is signed for MULH, DIV, REM.
    - MUL sign is irrelevant: the low word is taken from the unsigned magnitudes with sign fixup applied.
- Fast path (IDLE→DONE directly, RESULT loaded at the same edge):
  - DATA2=0, div-class: DIV/DIVU → 0xFFFFFFFF; REM/REMU → DATA1.
  - DIV/REM with DATA1=0x80000000 and DATA2=0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- CALC: one iteration per cycle, counter 0..31. After the 32nd iteration → FIXUP.
  - Multiply: if multiplier LSB set, add multiplicand into the upper half; shift right 1.
  - Divide (restoring): shift remainder:quotient left 1; trial-subtract divisor; set the quotient bit if non-negative.
- FIXUP (1 cycle):
  - Negate the 64-bit product when sign1 XOR sign2.
  - Negate the quotient when sign1 XOR sign2; negate the remainder when sign1.
  - Select the word: MUL → low 32; MULH/MULHSU/MULHU → high 32; DIV* → quotient; REM* → remainder.
  - Load RESULT; → DONE.
- DONE (1 cycle): DONE=1; START is ignored; → IDLE.
- STALL = (IDLE & START) | CALC | FIXUP.
  - STALL is low in DONE so the pipeline advances, capturing RESULT at that edge.
- Latency, with START seen in cycle t:
  - Normal: STALL high t..t+33; DONE at t+34.
  - Fast path: STALL high t only; DONE at t+1.
- FLUSH has priority over state advance.
  - In CALC/FIXUP, next state = IDLE, no DONE, RESULT unchanged.
  - In IDLE with START, the op is not accepted and STALL=0.
  - In DONE it has no effect.
- Back-to-back: START held through DONE starts the next op from IDLE in cycle t+35.
- Arithmetic is modulo 2^64 on the accumulator; the divide uses a 33-bit trial subtract; no overflow flags.

Decomposition:
- Shared package muldiv_pkg:
  - FUNCT3 op encodings.
  - State encoding (2-bit).
  - XLEN default.
  - Constants DIV0_QUOT (0xFFFFFFFF) and INT_MIN (0x80000000).
- One sub-module, muldiv_step: combinational single-iteration datapath. It takes the accumulator, operand and op class, and returns the next accumulator. The FSM, counter and fixup stay in muldiv_sequencer.

Test Plan:
1. MUL DATA1=7, DATA2=0xFFFFFFFD (-3) → RESULT=0xFFFFFFEB; STALL high exactly 34 cycles; DONE one pulse at t+34.
2. High-word multiplies:
   - MULH 0x80000000×0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. Divides:
   - DIV 0xFFFFFFF9 (-7)/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
   - DIVU 100/7 → 14; REMU 100/7 → 2.
4. Divide special cases:
   - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
   - All four: DONE at t+1; STALL high one cycle.
5. Abort and reset:
   - FLUSH asserted in the 10th CALC cycle → IDLE next cycle; no DONE; STALL low; the following START completes normally.
   - RESET_N low mid-CALC → immediately IDLE, RESULT=0, STALL=0.
6. START held high over two ops (MUL 3×4, then DIVU 9/2) → two DONE pulses, RESULT 12 then 4, with one IDLE cycle between.
